fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Instruction-fetch PC generator; sits directly downstream of the hazard controller and upstream of the I-cache.
- Consumes the controller's i2i stall/flush and load_pc redirect.
- Produces the fetch address for the I-cache and the PC/next-PC pair registered into the IF→DEC register.
- Holds redirects that arrive while fetch is stalled, so no redirect is lost.

Parameters:
PC_WIDTH, 32, width of all PC/address signals
RESET_PC, 32'h0040_0000, first fetch address after reset
PC_STEP, 4, sequential increment in bytes

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i2i_stall  in  1  hold current PC (from hazard controller)
i2i_flush  in  1  discard pending redirect and restart fetch at current PC
load_pc_we  in  1  redirect request
load_pc_new_pc  in  PC_WIDTH  redirect target
ic_resp_valid  in  1  I-cache returned valid data for ic_req_addr
ic_req_valid  out  1  fetch request valid
ic_req_addr  out  PC_WIDTH  fetch address, bits[1:0] always 0
if_pc  out  PC_WIDTH  PC of instruction being fetched (equals ic_req_addr)
if_pc_next  out  PC_WIDTH  ic_req_addr + PC_STEP, modulo 2^PC_WIDTH
redirect_pending  out  1  a redirect is latched and not yet applied
misaligned_redirect  out  1  one-cycle pulse: redirect target had bits[1:0] != 0

Behaviour:
- Async reset (rst_n low), all outputs:
  - pc_q = RESET_PC, state = BOOT
  - ic_req_valid = 0, redirect_pending = 0, misaligned_redirect = 0
  - pending_pc = 0
- Reset asserted mid-operation discards any pending redirect immediately.
- State BOOT:
  - ic_req_valid = 0 for exactly one cycle after rst_n rises.
  - Next state is RUN; pc_q is not changed.
- State RUN:
  - ic_req_valid = 1; ic_req_addr = pc_q.
  - If ic_resp_valid = 0, next state is MISS_WAIT and pc_q holds.
- State MISS_WAIT:
  - ic_req_valid = 1; address held.
  - Returns to RUN on the cycle ic_resp_valid = 1.
- PC update priority, evaluated each clock edge, highest first:
  1. i2i_flush=1: clear redirect_pending; pc_q holds; state becomes RUN.
  2. load_pc_we=1 and i2i_stall=0: pc_q = new_pc with [1:0] forced to 0; clear redirect_pending; state becomes RUN. This aborts an in-progress miss; the I-cache holds no registered request.
  3. load_pc_we=1 and i2i_stall=1: pending_pc = new_pc with [1:0] cleared; redirect_pending = 1; pc_q holds. Newest redirect overwrites any older pending one.
  4. i2i_stall=0 and redirect_pending=1: pc_q = pending_pc; redirect_pending = 0.
  5. i2i_stall=0 and ic_resp_valid=1: pc_q = pc_q + PC_STEP.
  6. Otherwise: pc_q holds.
- Timing and corner cases:
  - Latency: a redirect applied at edge N is presented on ic_req_addr in cycle N+1.
  - Redirect in BOOT is accepted per the rules above; BOOT still lasts one cycle.
  - Wrap-around: pc 32'hFFFF_FFFC + 4 gives 32'h0000_0000; no flag.
  - misaligned_redirect pulses in the cycle after any accepted redirect (rules 2 or 3) whose target has [1:0] != 0.
  - if_pc_next is combinational from pc_q.

Optional Feature:
- Macro: FETCH_PC_STATS_EN.
- When defined, adds three 32-bit saturating counters, reset to 0, on outputs stat_fetches, stat_redirects, stat_stall_cycles:
  - stat_fetches: cycles with ic_req_valid & ic_resp_valid & ~i2i_stall.
  - stat_redirects: applied redirects (rules 2 and 4).
  - stat_stall_cycles: cycles with i2i_stall=1.
  - Counters stop at 32'hFFFF_FFFF.
- When undefined: the ports still exist, are tied to 0, and no counter flops are built.

Test Plan:
- Reset release, no stalls, ic_resp_valid=1 → cycle 0 ic_req_valid=0; then addresses 0x00400000, 0x00400004, 0x00400008.
- ic_resp_valid=0 for 3 cycles at 0x00400008 → address held 3 cycles; state is MISS_WAIT; then advances to 0x0040000C.
- load_pc_we with 0x00401000 while i2i_stall=1 for 2 cycles → redirect_pending=1 while stalled; first unstalled cycle addr=0x00401000; pending cleared.
- Two redirects during one stall (0x100 then 0x200) → only 0x200 is fetched after the stall releases.
- Redirect to 0x00400012, and pc at 0xFFFFFFFC → addr 0x00400010 with misaligned_redirect one-cycle pulse; the wrap case fetches 0x00000000 next.
- rst_n asserted asynchronously while redirect_pending=1 → outputs reset immediately; after release, fetch restarts at RESET_PC with no redirect applied.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - I-cache fetch request/response bus between fetch PC unit and I-cache
interface fetch_pc_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic                ic_req_valid;
  logic [PC_WIDTH-1:0] ic_req_addr;
  logic                ic_resp_valid;

  modport master (
    output ic_req_valid,
    output ic_req_addr,
    input  ic_resp_valid
  );

  modport slave (
    input  ic_req_valid,
    input  ic_req_addr,
    output ic_resp_valid
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC generator with held redirects; FETCH_PC_STATS_EN enables stat counters
module fetch_pc_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(32'h0040_0000),
  parameter int                  PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i2i_stall,
  input  logic                i2i_flush,
  input  logic                load_pc_we,
  input  logic [PC_WIDTH-1:0] load_pc_new_pc,
  fetch_pc_unit_if.master     ic,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic [PC_WIDTH-1:0] if_pc_next,
  output logic                redirect_pending,
  output logic                misaligned_redirect,
  output logic [31:0]         stat_fetches,
  output logic [31:0]         stat_redirects,
  output logic [31:0]         stat_stall_cycles
);

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    MISS_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pending_pc_q, pending_pc_d;
  logic                pending_q, pending_d;
  logic                misaligned_q, misaligned_d;
  logic [PC_WIDTH-1:0] target_aligned;

  assign target_aligned = {load_pc_new_pc[PC_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      pending_pc_q <= '0;
      pending_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      pending_q    <= pending_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    pending_d    = pending_q;
    misaligned_d = 1'b0;

    case (state_q)
      BOOT:      state_d = RUN;
      RUN:       if (!ic.ic_resp_valid) state_d = MISS_WAIT;
      MISS_WAIT: if (ic.ic_resp_valid) state_d = RUN;
      default:   state_d = BOOT;
    endcase

    // Redirect priority: flush beats everything, a stalled redirect is parked.
    if (i2i_flush) begin
      pending_d = 1'b0;
      state_d   = RUN;
    end else if (load_pc_we && !i2i_stall) begin
      pc_d         = target_aligned;
      pending_d    = 1'b0;
      state_d      = RUN;
      misaligned_d = |load_pc_new_pc[1:0];
    end else if (load_pc_we) begin
      pending_pc_d = target_aligned;
      pending_d    = 1'b1;
      misaligned_d = |load_pc_new_pc[1:0];
    end else if (!i2i_stall && pending_q) begin
      pc_d      = pending_pc_q;
      pending_d = 1'b0;
    end else if (!i2i_stall && ic.ic_resp_valid && state_q != BOOT) begin
      pc_d = pc_q + PC_WIDTH'(PC_STEP);
    end
  end

  assign ic.ic_req_valid     = (state_q != BOOT);
  assign ic.ic_req_addr      = pc_q;
  assign if_pc               = pc_q;
  assign if_pc_next          = pc_q + PC_WIDTH'(PC_STEP);
  assign redirect_pending    = pending_q;
  assign misaligned_redirect = misaligned_q;

`ifdef FETCH_PC_STATS_EN
  logic        fetch_ev;
  logic        redirect_ev;
  logic [31:0] fetches_q, redirects_q, stalls_q;

  assign fetch_ev    = ic.ic_req_valid & ic.ic_resp_valid & ~i2i_stall;
  assign redirect_ev = ~i2i_flush & ~i2i_stall & (load_pc_we | pending_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetches_q   <= '0;
      redirects_q <= '0;
      stalls_q    <= '0;
    end else begin
      if (fetch_ev && fetches_q != '1)       fetches_q   <= fetches_q + 32'd1;
      if (redirect_ev && redirects_q != '1)  redirects_q <= redirects_q + 32'd1;
      if (i2i_stall && stalls_q != '1)       stalls_q    <= stalls_q + 32'd1;
    end
  end

  assign stat_fetches      = fetches_q;
  assign stat_redirects    = redirects_q;
  assign stat_stall_cycles = stalls_q;
`else
  assign stat_fetches      = '0;
  assign stat_redirects    = '0;
  assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard bench for fetch_pc_unit against a cycle-level reference model
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i2i_stall = 1'b0;
  logic        i2i_flush = 1'b0;
  logic        load_pc_we = 1'b0;
  logic [31:0] load_pc_new_pc = '0;
  logic [31:0] if_pc, if_pc_next;
  logic        redirect_pending, misaligned_redirect;
  logic [31:0] stat_fetches, stat_redirects, stat_stall_cycles;

  fetch_pc_unit_if #(.PC_WIDTH(32)) ic_bus ();

  fetch_pc_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i2i_stall           (i2i_stall),
    .i2i_flush           (i2i_flush),
    .load_pc_we          (load_pc_we),
    .load_pc_new_pc      (load_pc_new_pc),
    .ic                  (ic_bus.master),
    .if_pc               (if_pc),
    .if_pc_next          (if_pc_next),
    .redirect_pending    (redirect_pending),
    .misaligned_redirect (misaligned_redirect),
    .stat_fetches        (stat_fetches),
    .stat_redirects      (stat_redirects),
    .stat_stall_cycles   (stat_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic        pend;
    logic        mis;
    logic [31:0] sf, sr, ss;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural view of the fetch stream, no FSM.
  logic [31:0] m_pc, m_pend_pc, m_sf, m_sr, m_ss;
  logic        m_pend_v, m_booted, m_mis;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_pend_pc = '0; m_pend_v = 1'b0; m_booted = 1'b0; m_mis = 1'b0;
    m_sf = '0; m_sr = '0; m_ss = '0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.valid = m_booted;
    e.addr  = m_pc;
    e.pend  = m_pend_v;
    e.mis   = m_mis;
`ifdef FETCH_PC_STATS_EN
    e.sf = m_sf; e.sr = m_sr; e.ss = m_ss;
`else
    e.sf = '0; e.sr = '0; e.ss = '0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic model_update(input logic st, input logic fl, input logic we,
                              input logic [31:0] npc, input logic resp);
    if (st) m_ss++;
    if (m_booted && resp && !st) m_sf++;
    m_mis = 1'b0;
    if (fl) begin
      m_pend_v = 1'b0;
    end else if (we) begin
      m_mis = (npc % 4) != 0;
      if (!st) begin
        m_pc = npc - (npc % 4); m_pend_v = 1'b0; m_sr++;
      end else begin
        m_pend_pc = npc - (npc % 4); m_pend_v = 1'b1;
      end
    end else if (!st && m_pend_v) begin
      m_pc = m_pend_pc; m_pend_v = 1'b0; m_sr++;
    end else if (!st && resp && m_booted) begin
      m_pc = m_pc + 32'd4;
    end
    m_booted = 1'b1;
  endtask

  task automatic step(input logic st, input logic fl, input logic we,
                      input logic [31:0] npc, input logic resp);
    @(posedge clk); #1;
    rst_n = 1'b1;
    i2i_stall = st; i2i_flush = fl; load_pc_we = we; load_pc_new_pc = npc;
    ic_bus.ic_resp_valid = resp;
    push_exp();
    model_update(st, fl, we, npc, resp);
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk); #2;
    rst_n = 1'b0;
    i2i_stall = 1'b0; i2i_flush = 1'b0; load_pc_we = 1'b0; ic_bus.ic_resp_valid = 1'b1;
    #1;
    chk("async_rst_valid", 32'(ic_bus.ic_req_valid), 32'd0);
    chk("async_rst_addr", ic_bus.ic_req_addr, RST_PC);
    chk("async_rst_pending", 32'(redirect_pending), 32'd0);
    chk("async_rst_mis", 32'(misaligned_redirect), 32'd0);
    model_reset();
    push_exp();
    for (int i = 1; i < ncyc; i++) begin
      @(posedge clk); #1;
      push_exp();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("req_valid", 32'(ic_bus.ic_req_valid), 32'(e.valid));
        chk("req_addr", ic_bus.ic_req_addr, e.addr);
        chk("if_pc", if_pc, e.addr);
        chk("if_pc_next", if_pc_next, e.addr + 32'd4);
        chk("redirect_pending", 32'(redirect_pending), 32'(e.pend));
        chk("misaligned", 32'(misaligned_redirect), 32'(e.mis));
        chk("stat_fetches", stat_fetches, e.sf);
        chk("stat_redirects", stat_redirects, e.sr);
        chk("stat_stalls", stat_stall_cycles, e.ss);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] npc;
    logic        st, fl, we, resp;
    ic_bus.ic_resp_valid = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      push_exp();
    end
    // Boot and sequential fetch, then a 3-cycle miss at 0x00400008
    repeat (3) step(0, 0, 0, '0, 1);
    repeat (3) step(0, 0, 0, '0, 0);
    repeat (2) step(0, 0, 0, '0, 1);
    // Redirect held across a 2-cycle stall
    step(1, 0, 1, 32'h0040_1000, 1);
    step(1, 0, 0, '0, 1);
    repeat (2) step(0, 0, 0, '0, 1);
    // Newest stalled redirect wins
    step(1, 0, 1, 32'h0000_0100, 1);
    step(1, 0, 1, 32'h0000_0200, 1);
    repeat (2) step(0, 0, 0, '0, 1);
    // Misaligned target and wrap-around
    step(0, 0, 1, 32'h0040_0012, 1);
    repeat (2) step(0, 0, 0, '0, 1);
    step(0, 0, 1, 32'hFFFF_FFFC, 1);
    repeat (3) step(0, 0, 0, '0, 1);
    // Flush discards a pending redirect
    step(1, 0, 1, 32'h0000_3000, 1);
    step(0, 1, 0, '0, 1);
    repeat (2) step(0, 0, 0, '0, 1);
    // Redirect during the boot cycle
    do_reset(2);
    step(0, 0, 1, 32'h0000_5000, 1);
    repeat (2) step(0, 0, 0, '0, 1);
    // Reset while a redirect is pending
    step(1, 0, 1, 32'h0000_7004, 1);
    do_reset(2);
    repeat (4) step(0, 0, 0, '0, 1);
    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1 + $urandom_range(0, 1));
      end else begin
        st   = ($urandom_range(0, 99) < 30);
        fl   = ($urandom_range(0, 99) < 5);
        we   = ($urandom_range(0, 99) < 15);
        resp = ($urandom_range(0, 99) < 70);
        npc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
        step(st, fl, we, npc, resp);
      end
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
